irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Interrupt controller that sequences entry to and exit from interrupt service for the fetch stage.
- Latches four interrupt sources into sticky pending bits, applies per-source masks and a global enable, and selects one source by fixed priority.
- Presents that source's vector address to fetch through a req/ack handshake, then tracks the in-service source until fetch reports `rti`.
- A small config port lets software read and write the mask, pending and enable state.

Parameters:
- N_SRC, 4, number of interrupt sources; the only supported value is 4.
- VEC0, 32'h00000020, vector address for source 0 (IO 0).
- VEC1, 32'h00000040, vector address for source 1 (IO 1).
- VEC2, 32'h00000060, vector address for source 2 (counter 0).
- VEC3, 32'h00000080, vector address for source 3 (counter 1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset, sampled on posedge clk.
- irq_src  in  4  raw interrupt sources; bit i is source i.
- irq_ack  in  1  fetch has redirected the PC to irq_vector this cycle.
- rti  in  1  return-from-interrupt retired by fetch.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  2  config register select.
- cfg_wdata  in  32  config write data.
- cfg_rdata  out  32  config read data; combinational from cfg_addr.
- irq_req  out  1  interrupt request to fetch.
- irq_vector  out  32  target PC for the selected source.
- irq_id  out  2  index of the selected or in-service source.
- in_service  out  1  a handler is currently running.
- irq_done  out  1  one-cycle pulse when rti ends service.

Behaviour:
- Reset (reset==0 at posedge):
  - pending=0, mask=4'h0, gie=1, state=IDLE, spurious=0.
  - irq_req=0, irq_vector=0, irq_id=0, in_service=0, irq_done=0.
  - Reset wins over every other event, including mid-REQ and mid-SERVICE.
- Pending bits:
  - pending[i] is set on any posedge where the source input is active (see Optional Feature).
  - It clears on irq_ack while irq_id==i, or on a cfg write of 1 to PENDING bit i (write-1-to-clear).
  - On the ack edge, clear beats set for the acknowledged bit. A level source still high re-pends on the next edge.
  - A cfg clear and a source set in the same cycle: set wins.
- eligible = pending & mask. Priority: lowest index wins (0 highest).
- States:
  - IDLE: if gie and eligible!=0, go to REQ. Register irq_id = the winner and irq_vector = VEC[winner]. irq_req=1 from the next cycle.
  - REQ: irq_req=1. irq_id and irq_vector are held stable; a request is never withdrawn, even if the mask or gie changes. On irq_ack: go to SERVICE, in_service=1, irq_req=0 in the same edge.
  - SERVICE: no new request is raised (no nesting). On rti: go to IDLE, in_service=0, irq_done=1 for exactly one cycle.
- rti seen in IDLE or REQ is ignored and sets the sticky spurious flag. In REQ, irq_ack together with rti: the ack is taken and rti counts as spurious.
- irq_ack outside REQ is ignored.
- Latency: source asserted before edge 0 → pending after edge 0 → REQ (irq_req=1) after edge 1.
- Back-to-back: after irq_done, a still-eligible source can re-enter REQ on the very next edge.
- Config map, read/write:
  - 0 MASK[3:0].
  - 1 PENDING[3:0], write-1-to-clear.
  - 2 GIE[0].
  - 3 STATUS, read-only: {spurious[8], state[5:4], in_service[2], irq_id[1:0]}.
  - Writing 1 to STATUS bit 8 clears spurious.
  - Unused bits read 0.

Optional Feature:
- Macro IRQ_EDGE_DETECT_EN.
- Defined: one registered sample of irq_src per source. Pending sets only on a 0→1 transition, so a held-high source pends once. The sample register resets to 0, so a source already high at reset release pends once.
- Undefined: level-sensitive. Pending sets on every edge where the source is high.

Decomposition:
- Shared package irq_pkg holds:
  - the state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2);
  - the config address constants (CFG_MASK, CFG_PEND, CFG_GIE, CFG_STATUS);
  - the STATUS bit positions.
- One natural sub-module: irq_prio_enc, a 4-bit fixed-priority encoder producing a valid flag and a 2-bit index.

Test Plan:
- Pending without mask, then unmask: mask=4'h0, pulse irq_src[2] → pending=4'b0100, irq_req=0. Write MASK=4'hF → irq_req=1 two edges later, irq_id=2, irq_vector=32'h60.
- Simultaneous sources and priority: MASK=4'hF, irq_src=4'b1010 → irq_id=1. Ack then rti → irq_done pulse. Next REQ has irq_id=3 and irq_vector=32'h80.
- Stability in REQ: in REQ with irq_id=1, raise irq_src[0] and clear MASK → irq_req, irq_id and irq_vector stay unchanged until irq_ack.
- No nesting and spurious rti:
  - During SERVICE, assert irq_src[0] → no irq_req until rti.
  - rti in IDLE → STATUS bit 8 set, state unchanged.
- Reset mid-SERVICE: reset=0 for one edge → in_service=0, irq_req=0, pending=0, MASK=0.
- Edge detect: hold irq_src[3] high for 10 cycles.
  - With IRQ_EDGE_DETECT_EN: exactly one service.
  - Without it: re-pends right after the ack.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller: FSM encoding,
// config register addresses and STATUS register bit positions.
package irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_t;

   localparam logic [1:0] CFG_MASK   = 2'd0;
   localparam logic [1:0] CFG_PEND   = 2'd1;
   localparam logic [1:0] CFG_GIE    = 2'd2;
   localparam logic [1:0] CFG_STATUS = 2'd3;

   localparam int ST_ID_LO    = 0;
   localparam int ST_INSVC    = 2;
   localparam int ST_STATE_LO = 4;
   localparam int ST_SPUR     = 8;

endpackage

// File: rtl/irq_prio_enc.sv
// 4-bit fixed-priority encoder; bit 0 has the highest priority.
module irq_prio_enc (
   input  logic [3:0] req,
   output logic       valid,
   output logic [1:0] idx
);

   always_comb begin
      valid = |req;
      idx   = 2'd0;
      if (req[0])      idx = 2'd0;
      else if (req[1]) idx = 2'd1;
      else if (req[2]) idx = 2'd2;
      else if (req[3]) idx = 2'd3;
   end

endmodule

// File: rtl/irq_controller.sv
// Interrupt entry/exit sequencer for fetch: sticky pending, mask, priority, req/ack, rti.
// Define IRQ_EDGE_DETECT_EN for rising-edge sources; default is level-sensitive.
//
// state   | meaning
// IDLE    | no request outstanding, waiting for an enabled pending source
// REQ     | irq_req held to fetch with a frozen irq_id/irq_vector until irq_ack
// SERVICE | handler running, no new request until rti
module irq_controller
   import irq_pkg::*;
#(
   parameter int          N_SRC = 4,
   parameter logic [31:0] VEC0  = 32'h0000_0020,
   parameter logic [31:0] VEC1  = 32'h0000_0040,
   parameter logic [31:0] VEC2  = 32'h0000_0060,
   parameter logic [31:0] VEC3  = 32'h0000_0080
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             irq_ack,
   input  logic             rti,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [31:0]      cfg_wdata,
   output logic [31:0]      cfg_rdata,
   output logic             irq_req,
   output logic [31:0]      irq_vector,
   output logic [1:0]       irq_id,
   output logic             in_service,
   output logic             irq_done
);

   irq_state_t       state, state_nxt;
   logic [N_SRC-1:0] pending, mask, src_set, ack_clr, cfg_clr;
   logic             gie, spurious;
   logic             win_valid;
   logic [1:0]       win_idx;
   logic [31:0]      win_vec;
   logic             unused_wdata;

   assign unused_wdata = ^{cfg_wdata[31:9], cfg_wdata[7:4]};

   irq_prio_enc u_prio (
      .req   (pending & mask),
      .valid (win_valid),
      .idx   (win_idx)
   );

   always_comb begin
      case (win_idx)
         2'd0:    win_vec = VEC0;
         2'd1:    win_vec = VEC1;
         2'd2:    win_vec = VEC2;
         default: win_vec = VEC3;
      endcase
   end

`ifdef IRQ_EDGE_DETECT_EN
   logic [N_SRC-1:0] src_q;

   // Sample resets to 0 so a source already high at reset release pends once.
   always_ff @(posedge clk) begin
      if (!reset) src_q <= '0;
      else        src_q <= irq_src;
   end

   assign src_set = irq_src & ~src_q;
`else
   assign src_set = irq_src;
`endif

   assign ack_clr = (state == REQ && irq_ack) ? (N_SRC'(1) << irq_id) : '0;
   assign cfg_clr = (cfg_we && cfg_addr == CFG_PEND) ? cfg_wdata[N_SRC-1:0] : '0;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gie && win_valid) state_nxt = REQ;
         REQ:     if (irq_ack)          state_nxt = SERVICE;
         SERVICE: if (rti)              state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
   end

   always_comb begin
      irq_req    = (state == REQ);
      in_service = (state == SERVICE);
   end

   // Source set beats a cfg clear; an ack clear beats a source set.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pending    <= '0;
         mask       <= '0;
         gie        <= 1'b1;
         spurious   <= 1'b0;
         irq_id     <= 2'd0;
         irq_vector <= 32'd0;
         irq_done   <= 1'b0;
      end else begin
         pending  <= ((pending & ~cfg_clr) | src_set) & ~ack_clr;
         irq_done <= (state == SERVICE) && rti;
         if (cfg_we && cfg_addr == CFG_MASK) mask <= cfg_wdata[N_SRC-1:0];
         if (cfg_we && cfg_addr == CFG_GIE)  gie  <= cfg_wdata[0];
         if (rti && state != SERVICE)
            spurious <= 1'b1;
         else if (cfg_we && cfg_addr == CFG_STATUS && cfg_wdata[ST_SPUR])
            spurious <= 1'b0;
         if (state == IDLE && gie && win_valid) begin
            irq_id     <= win_idx;
            irq_vector <= win_vec;
         end
      end
   end

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         CFG_MASK: cfg_rdata[N_SRC-1:0] = mask;
         CFG_PEND: cfg_rdata[N_SRC-1:0] = pending;
         CFG_GIE:  cfg_rdata[0]         = gie;
         default: begin
            cfg_rdata[ST_SPUR]          = spurious;
            cfg_rdata[ST_STATE_LO +: 2] = state;
            cfg_rdata[ST_INSVC]         = in_service;
            cfg_rdata[ST_ID_LO +: 2]    = irq_id;
         end
      endcase
   end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: stimulus pushes expected REQ/DONE events,
// a negedge monitor pops and compares them as the DUT raises irq_req or irq_done.
module tb_irq_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  irq_src;
   logic        irq_ack, rti, cfg_we;
   logic [1:0]  cfg_addr;
   logic [31:0] cfg_wdata, cfg_rdata, irq_vector;
   logic        irq_req, in_service, irq_done;
   logic [1:0]  irq_id;

   typedef struct {
      bit          is_done;
      logic [1:0]  id;
      logic [31:0] vec;
   } ev_t;

   ev_t  exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic req_q  = 1'b0;

   irq_controller dut (
      .clk        (clk),
      .reset      (reset),
      .irq_src    (irq_src),
      .irq_ack    (irq_ack),
      .rti        (rti),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cfg_rdata  (cfg_rdata),
      .irq_req    (irq_req),
      .irq_vector (irq_vector),
      .irq_id     (irq_id),
      .in_service (in_service),
      .irq_done   (irq_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      tick();
      cfg_we = 1'b0; cfg_wdata = '0;
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      cfg_addr = a;
      #1;
      chk(name, cfg_rdata, exp);
   endtask

   task automatic push_req(input logic [1:0] id, input logic [31:0] vec);
      ev_t e;
      e.is_done = 1'b0; e.id = id; e.vec = vec;
      exp_q.push_back(e);
   endtask

   task automatic push_done(input logic [1:0] id);
      ev_t e;
      e.is_done = 1'b1; e.id = id; e.vec = '0;
      exp_q.push_back(e);
   endtask

   task automatic pulse_src(input logic [3:0] s);
      irq_src = s;
      tick();
      irq_src = '0;
   endtask

   task automatic ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic do_rti();
      rti = 1'b1;
      tick();
      rti = 1'b0;
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (reset === 1'b1) begin
         if (irq_req && !req_q) begin
            if (exp_q.size() == 0) chk("unexpected_req", {30'd0, irq_id}, 32'hFFFF_FFFF);
            else begin
               e = exp_q.pop_front();
               chk("sb_req_kind", {31'd0, e.is_done}, 32'd0);
               chk("sb_req_id", {30'd0, irq_id}, {30'd0, e.id});
               chk("sb_req_vec", irq_vector, e.vec);
            end
         end
         if (irq_done) begin
            if (exp_q.size() == 0) chk("unexpected_done", {30'd0, irq_id}, 32'hFFFF_FFFF);
            else begin
               e = exp_q.pop_front();
               chk("sb_done_kind", {31'd0, e.is_done}, 32'd1);
               chk("sb_done_id", {30'd0, irq_id}, {30'd0, e.id});
            end
         end
      end
      req_q <= irq_req;
   end

   initial begin
      reset = 1'b0; irq_src = '0; irq_ack = 1'b0; rti = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      tick(); tick();
      reset = 1'b1;
      chk("rst_req", {31'd0, irq_req}, 32'd0);
      chk("rst_insvc", {31'd0, in_service}, 32'd0);
      chk("rst_id", {30'd0, irq_id}, 32'd0);
      chk("rst_vec", irq_vector, 32'd0);
      chk("rst_done", {31'd0, irq_done}, 32'd0);
      rd_chk("rst_mask", 2'd0, 32'd0);
      rd_chk("rst_pend", 2'd1, 32'd0);
      rd_chk("rst_gie", 2'd2, 32'd1);
      rd_chk("rst_status", 2'd3, 32'd0);

      // pending while masked, then unmask
      pulse_src(4'b0100);
      rd_chk("masked_pend", 2'd1, 32'h4);
      tick();
      chk("masked_noreq", {31'd0, irq_req}, 32'd0);
      push_req(2'd2, 32'h60);
      wr(2'd0, 32'hF);
      chk("unmask_req_lat", {31'd0, irq_req}, 32'd0);
      tick();
      chk("unmask_req", {31'd0, irq_req}, 32'd1);
      ack();
      chk("ack_insvc", {31'd0, in_service}, 32'd1);
      chk("ack_req_drop", {31'd0, irq_req}, 32'd0);
      rd_chk("ack_pend_clr", 2'd1, 32'd0);
      push_done(2'd2);
      do_rti();
      chk("rti_insvc", {31'd0, in_service}, 32'd0);
      tick();
      chk("done_one_cycle", {31'd0, irq_done}, 32'd0);

      // simultaneous sources: priority and back-to-back re-entry
      push_req(2'd1, 32'h40);
      pulse_src(4'b1010);
      tick();
      chk("prio_id", {30'd0, irq_id}, 32'd1);
      ack();
      push_done(2'd1);
      push_req(2'd3, 32'h80);
      do_rti();
      tick();
      chk("b2b_req", {31'd0, irq_req}, 32'd1);
      ack();
      push_done(2'd3);
      do_rti();
      tick();

      // request stays frozen while mask and sources change
      push_req(2'd1, 32'h40);
      pulse_src(4'b0010);
      tick();
      irq_src = 4'b0001;
      wr(2'd0, 32'h0);
      irq_src = '0;
      for (int i = 0; i < 3; i++) begin
         chk("hold_req", {31'd0, irq_req}, 32'd1);
         chk("hold_id", {30'd0, irq_id}, 32'd1);
         chk("hold_vec", irq_vector, 32'h40);
         tick();
      end
      ack();
      push_done(2'd1);
      do_rti();
      tick();
      chk("masked_idle", {31'd0, irq_req}, 32'd0);
      wr(2'd1, 32'hF);
      rd_chk("w1c_pend", 2'd1, 32'd0);
      wr(2'd0, 32'hF);

      // no nesting during service
      push_req(2'd2, 32'h60);
      pulse_src(4'b0100);
      tick();
      ack();
      pulse_src(4'b0001);
      for (int i = 0; i < 4; i++) begin
         chk("no_nest", {31'd0, irq_req}, 32'd0);
         tick();
      end
      push_done(2'd2);
      push_req(2'd0, 32'h20);
      do_rti();
      tick();
      ack();
      push_done(2'd0);
      do_rti();
      tick();

      // spurious rti in IDLE
      do_rti();
      rd_chk("spur_set", 2'd3, 32'h100);
      chk("spur_state", {31'd0, irq_req | in_service}, 32'd0);
      wr(2'd3, 32'h100);
      rd_chk("spur_clr", 2'd3, 32'd0);

      // reset in the middle of service
      push_req(2'd1, 32'h40);
      pulse_src(4'b0010);
      tick();
      ack();
      pulse_src(4'b0100);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mid_rst_insvc", {31'd0, in_service}, 32'd0);
      chk("mid_rst_req", {31'd0, irq_req}, 32'd0);
      rd_chk("mid_rst_pend", 2'd1, 32'd0);
      rd_chk("mid_rst_mask", 2'd0, 32'd0);
      tick();
      chk("mid_rst_nodone", {31'd0, irq_done}, 32'd0);

      // source held high for 10 cycles
      wr(2'd0, 32'hF);
      push_req(2'd3, 32'h80);
      irq_src = 4'b1000;
      tick();
      rd_chk("hold_pend", 2'd1, 32'h8);
      tick();
      ack();
      rd_chk("ack_beats_set", 2'd1, 32'd0);
      tick();
`ifdef IRQ_EDGE_DETECT_EN
      rd_chk("edge_no_repend", 2'd1, 32'd0);
      push_done(2'd3);
`else
      rd_chk("level_repend", 2'd1, 32'h8);
      push_done(2'd3);
      push_req(2'd3, 32'h80);
`endif
      do_rti();
      for (int i = 0; i < 5; i++) tick();
      irq_src = '0;
`ifdef IRQ_EDGE_DETECT_EN
      chk("edge_single", {31'd0, irq_req}, 32'd0);
`else
      chk("level_again", {31'd0, irq_req}, 32'd1);
      ack();
      push_done(2'd3);
      do_rti();
`endif
      tick();
      rd_chk("end_pend", 2'd1, 32'd0);
      chk("end_insvc", {31'd0, in_service}, 32'd0);

      repeat (3) tick();
      chk("sb_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
